// File: rtl/eth_arp_rx_cache.sv
// GMII ARP receiver with a small IP->MAC cache and round-robin eviction.
// Define ARP_RX_FCS_CHECK_EN to qualify acceptance on CRC-32 and min length.
module eth_arp_rx_cache #(
   parameter logic [47:0] BOARD_MAC   = 48'h00_11_22_33_44_55,
   parameter logic [31:0] BOARD_IP    = {8'd192, 8'd168, 8'd1, 8'd10},
   parameter int          CACHE_DEPTH = 4
) (
   input  logic                         i_gmii_rxc,
   input  logic                         i_rst_n,
   input  logic                         i_gmii_rx_dv,
   input  logic [7:0]                   i_gmii_rxd,
   output logic                         o_arp_rx_done,
   output logic                         o_arp_rx_type,
   output logic [47:0]                  o_arp_srcmac_addr,
   output logic [31:0]                  o_arp_srcip_addr,
   input  logic                         i_lookup_req,
   input  logic [31:0]                  i_lookup_ip,
   output logic                         o_lookup_vld,
   output logic                         o_lookup_hit,
   output logic [47:0]                  o_lookup_mac,
   input  logic                         i_cache_clr,
   output logic [$clog2(CACHE_DEPTH):0] o_cache_cnt
);

   localparam int IW = $clog2(CACHE_DEPTH);
   localparam int CW = IW + 1;

   typedef enum logic [2:0] {
      IDLE, PREAMBLE, ETH_HEAD, ARP_DATA, RX_END
`ifdef ARP_RX_FCS_CHECK_EN
      , FCS
`endif
   } state_t;

   state_t        state_q, state_d;
   logic [4:0]    cnt_q, cnt_d;
   logic [47:0]   dst_q, dst_d;
   logic [7:0]    typ_q, typ_d;
   logic [15:0]   op_q, op_d;
   logic [47:0]   smac_q, smac_d;
   logic [31:0]   sip_q, sip_d;
   logic [23:0]   tip_q, tip_d;
   logic          done_q, done_d;
   logic          type_q, type_d;
   logic [47:0]   srcmac_q, srcmac_d;
   logic [31:0]   srcip_q, srcip_d;
   logic          arp_ok;
`ifdef ARP_RX_FCS_CHECK_EN
   logic [31:0]   crc_q, crc_d, crc_rev;
   logic [6:0]    len_q, len_d;
   logic          fcs_ok;

   function automatic logic [31:0] crc_byte(input logic [31:0] c,
                                            input logic [7:0]  d);
      logic [31:0] r;
      r = c;
      for (int i = 0; i < 8; i++)
         r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
      return r;
   endfunction
`endif

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      dst_d    = dst_q;
      typ_d    = typ_q;
      op_d     = op_q;
      smac_d   = smac_q;
      sip_d    = sip_q;
      tip_d    = tip_q;
      done_d   = 1'b0;
      type_d   = type_q;
      srcmac_d = srcmac_q;
      srcip_d  = srcip_q;
      arp_ok   = (op_q == 16'd1 || op_q == 16'd2) &&
                 ({tip_q, i_gmii_rxd} == BOARD_IP);
`ifdef ARP_RX_FCS_CHECK_EN
      crc_d   = crc_q;
      len_d   = len_q;
      crc_rev = {<<{crc_q}};
      fcs_ok  = (crc_rev == 32'hC704_DD7B) && (len_q >= 7'd64);
      if (i_gmii_rx_dv &&
          (state_q == ETH_HEAD || state_q == ARP_DATA || state_q == FCS)) begin
         crc_d = crc_byte(crc_q, i_gmii_rxd);
         if (len_q != 7'h7f) len_d = len_q + 7'd1;
      end
`endif
      unique case (state_q)
         IDLE: begin
            if (i_gmii_rx_dv && i_gmii_rxd == 8'h55) begin
               state_d = PREAMBLE;
               cnt_d   = '0;
            end
         end
         PREAMBLE: begin
            if (!i_gmii_rx_dv) begin
               state_d = IDLE;
            end else if (cnt_q < 5'd6) begin
               if (i_gmii_rxd == 8'h55) cnt_d = cnt_q + 5'd1;
               else state_d = RX_END;
            end else if (i_gmii_rxd == 8'hD5) begin
               state_d = ETH_HEAD;
               cnt_d   = '0;
`ifdef ARP_RX_FCS_CHECK_EN
               crc_d   = '1;
               len_d   = '0;
`endif
            end else begin
               state_d = RX_END;
            end
         end
         ETH_HEAD: begin
            if (!i_gmii_rx_dv) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 5'd1;
               if (cnt_q < 5'd6) dst_d = {dst_q[39:0], i_gmii_rxd};
               if (cnt_q == 5'd12) typ_d = i_gmii_rxd;
               if (cnt_q == 5'd13) begin
                  cnt_d = '0;
                  if ((dst_q == BOARD_MAC || dst_q == '1) &&
                      {typ_q, i_gmii_rxd} == 16'h0806)
                     state_d = ARP_DATA;
                  else
                     state_d = RX_END;
               end
            end
         end
         ARP_DATA: begin
            if (!i_gmii_rx_dv) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 5'd1;
               if (cnt_q == 5'd6 || cnt_q == 5'd7)
                  op_d = {op_q[7:0], i_gmii_rxd};
               if (cnt_q >= 5'd8 && cnt_q <= 5'd13)
                  smac_d = {smac_q[39:0], i_gmii_rxd};
               if (cnt_q >= 5'd14 && cnt_q <= 5'd17)
                  sip_d = {sip_q[23:0], i_gmii_rxd};
               if (cnt_q >= 5'd24)
                  tip_d = {tip_q[15:0], i_gmii_rxd};
               if (cnt_q == 5'd27) begin
                  cnt_d   = '0;
                  state_d = RX_END;
`ifdef ARP_RX_FCS_CHECK_EN
                  if (arp_ok) state_d = FCS;
`else
                  if (arp_ok) begin
                     done_d   = 1'b1;
                     type_d   = (op_q == 16'd2);
                     srcmac_d = smac_q;
                     srcip_d  = sip_q;
                  end
`endif
               end
            end
         end
`ifdef ARP_RX_FCS_CHECK_EN
         // Frame end is the dv falling edge; that is when the residue is final.
         FCS: begin
            if (!i_gmii_rx_dv) begin
               state_d = IDLE;
               if (fcs_ok) begin
                  done_d   = 1'b1;
                  type_d   = (op_q == 16'd2);
                  srcmac_d = smac_q;
                  srcip_d  = sip_q;
               end
            end
         end
`endif
         RX_END: begin
            if (!i_gmii_rx_dv) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_gmii_rxc or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         dst_q    <= '0;
         typ_q    <= '0;
         op_q     <= '0;
         smac_q   <= '0;
         sip_q    <= '0;
         tip_q    <= '0;
         done_q   <= 1'b0;
         type_q   <= 1'b0;
         srcmac_q <= '0;
         srcip_q  <= '0;
`ifdef ARP_RX_FCS_CHECK_EN
         crc_q    <= '1;
         len_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         dst_q    <= dst_d;
         typ_q    <= typ_d;
         op_q     <= op_d;
         smac_q   <= smac_d;
         sip_q    <= sip_d;
         tip_q    <= tip_d;
         done_q   <= done_d;
         type_q   <= type_d;
         srcmac_q <= srcmac_d;
         srcip_q  <= srcip_d;
`ifdef ARP_RX_FCS_CHECK_EN
         crc_q    <= crc_d;
         len_q    <= len_d;
`endif
      end
   end

   assign o_arp_rx_done     = done_q;
   assign o_arp_rx_type     = type_q;
   assign o_arp_srcmac_addr = srcmac_q;
   assign o_arp_srcip_addr  = srcip_q;

   logic [CACHE_DEPTH-1:0] vld_q, vld_d;
   logic [31:0]            ip_q  [CACHE_DEPTH];
   logic [31:0]            ip_d  [CACHE_DEPTH];
   logic [47:0]            mac_q [CACHE_DEPTH];
   logic [47:0]            mac_d [CACHE_DEPTH];
   logic [IW-1:0]          ptr_q, ptr_d;
   logic                   lk_vld_q, lk_vld_d;
   logic                   lk_hit_q, lk_hit_d;
   logic [47:0]            lk_mac_q, lk_mac_d;
   logic                   wr_en, m_hit, f_hit;
   logic [IW-1:0]          m_idx, f_idx, w_idx;

   // The write commits at the end of the pulse cycle, so a lookup issued
   // in that cycle still sees the old contents.
   always_comb begin
      vld_d    = vld_q;
      ip_d     = ip_q;
      mac_d    = mac_q;
      ptr_d    = ptr_q;
      lk_vld_d = i_lookup_req;
      lk_hit_d = 1'b0;
      lk_mac_d = '0;
      m_hit    = 1'b0;
      m_idx    = '0;
      f_hit    = 1'b0;
      f_idx    = '0;
      w_idx    = ptr_q;
      wr_en    = done_q && (srcip_q != '0);
      for (int i = CACHE_DEPTH - 1; i >= 0; i--) begin
         if (vld_q[i] && ip_q[i] == srcip_q) begin
            m_hit = 1'b1;
            m_idx = IW'(i);
         end
         if (!vld_q[i]) begin
            f_hit = 1'b1;
            f_idx = IW'(i);
         end
         if (i_lookup_req && vld_q[i] && ip_q[i] == i_lookup_ip) begin
            lk_hit_d = 1'b1;
            lk_mac_d = mac_q[i];
         end
      end
      if (i_cache_clr) begin
         vld_d = '0;
         ptr_d = '0;
      end else if (wr_en) begin
         if (m_hit) begin
            w_idx = m_idx;
         end else if (f_hit) begin
            w_idx = f_idx;
         end else begin
            w_idx = ptr_q;
            ptr_d = ptr_q + 1'b1;
         end
         vld_d[w_idx] = 1'b1;
         ip_d[w_idx]  = srcip_q;
         mac_d[w_idx] = srcmac_q;
      end
   end

   always_ff @(posedge i_gmii_rxc or negedge i_rst_n) begin
      if (!i_rst_n) begin
         vld_q    <= '0;
         ptr_q    <= '0;
         lk_vld_q <= 1'b0;
         lk_hit_q <= 1'b0;
         lk_mac_q <= '0;
         for (int i = 0; i < CACHE_DEPTH; i++) begin
            ip_q[i]  <= '0;
            mac_q[i] <= '0;
         end
      end else begin
         vld_q    <= vld_d;
         ptr_q    <= ptr_d;
         lk_vld_q <= lk_vld_d;
         lk_hit_q <= lk_hit_d;
         lk_mac_q <= lk_mac_d;
         ip_q     <= ip_d;
         mac_q    <= mac_d;
      end
   end

   always_comb begin
      o_cache_cnt = '0;
      for (int i = 0; i < CACHE_DEPTH; i++)
         o_cache_cnt = o_cache_cnt + CW'(vld_q[i]);
   end

   assign o_lookup_vld = lk_vld_q;
   assign o_lookup_hit = lk_hit_q;
   assign o_lookup_mac = lk_mac_q;

endmodule

// File: tb/tb_eth_arp_rx_cache.sv
// Directed ARP frames against eth_arp_rx_cache with hand-computed results.
// Define ARP_RX_FCS_CHECK_EN for bench and RTL together to cover FCS checks.
module tb_eth_arp_rx_cache;

   localparam logic [47:0] BMAC  = 48'h00_11_22_33_44_55;
   localparam logic [47:0] BCAST = 48'hFF_FF_FF_FF_FF_FF;
   localparam logic [31:0] BIP   = 32'hC0A8_010A;
   localparam logic [47:0] M2    = 48'h00_0A_35_01_02_03;

   logic        clk = 1'b0;
   logic        i_rst_n;
   logic        i_gmii_rx_dv;
   logic [7:0]  i_gmii_rxd;
   logic        o_arp_rx_done;
   logic        o_arp_rx_type;
   logic [47:0] o_arp_srcmac_addr;
   logic [31:0] o_arp_srcip_addr;
   logic        i_lookup_req;
   logic [31:0] i_lookup_ip;
   logic        o_lookup_vld;
   logic        o_lookup_hit;
   logic [47:0] o_lookup_mac;
   logic        i_cache_clr;
   logic [2:0]  o_cache_cnt;

   int n_chk = 0;
   int n_err = 0;
   int pulses = 0;
   int cyc = 0;
   int pulse_cyc = 0;
   int tip_cyc = 0;
   int fall_cyc = 0;
   int p0;

   eth_arp_rx_cache dut (
      .i_gmii_rxc        (clk),
      .i_rst_n           (i_rst_n),
      .i_gmii_rx_dv      (i_gmii_rx_dv),
      .i_gmii_rxd        (i_gmii_rxd),
      .o_arp_rx_done     (o_arp_rx_done),
      .o_arp_rx_type     (o_arp_rx_type),
      .o_arp_srcmac_addr (o_arp_srcmac_addr),
      .o_arp_srcip_addr  (o_arp_srcip_addr),
      .i_lookup_req      (i_lookup_req),
      .i_lookup_ip       (i_lookup_ip),
      .o_lookup_vld      (o_lookup_vld),
      .o_lookup_hit      (o_lookup_hit),
      .o_lookup_mac      (o_lookup_mac),
      .i_cache_clr       (i_cache_clr),
      .o_cache_cnt       (o_cache_cnt)
   );

   always #4 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (o_arp_rx_done) begin
         pulses = pulses + 1;
         pulse_cyc = cyc;
      end
   end

   function automatic logic [31:0] ip_of(input int n);
      return {24'hC0A801, n[7:0]};
   endfunction

   function automatic logic [47:0] mac_of(input int n);
      return {40'h00_0A_35_01_00, n[7:0]};
   endfunction

   function automatic logic [31:0] crc_upd(input logic [31:0] c,
                                           input logic [7:0]  d);
      logic [31:0] r;
      r = c;
      for (int i = 0; i < 8; i++) begin
         if (r[0] ^ d[i]) r = (r >> 1) ^ 32'hEDB8_8320;
         else r = r >> 1;
      end
      return r;
   endfunction

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0h want %0h", tag, got, exp);
      end
   endtask

   task automatic send_frame(input logic [47:0] dst, input logic [15:0] etype,
                             input logic [15:0] op, input logic [47:0] smac,
                             input logic [31:0] sip, input logic [31:0] tip,
                             input int cut, input int rst_at, input bit flip);
      logic [7:0]  b[$];
      logic [31:0] c;
      bit          early;
      b = {};
      early = 1'b0;
      repeat (7) b.push_back(8'h55);
      b.push_back(8'hD5);
      for (int i = 5; i >= 0; i--) b.push_back(dst[i*8 +: 8]);
      for (int i = 5; i >= 0; i--) b.push_back(smac[i*8 +: 8]);
      b.push_back(etype[15:8]);
      b.push_back(etype[7:0]);
      b.push_back(8'h00); b.push_back(8'h01);
      b.push_back(8'h08); b.push_back(8'h00);
      b.push_back(8'h06); b.push_back(8'h04);
      b.push_back(op[15:8]);
      b.push_back(op[7:0]);
      for (int i = 5; i >= 0; i--) b.push_back(smac[i*8 +: 8]);
      for (int i = 3; i >= 0; i--) b.push_back(sip[i*8 +: 8]);
      repeat (6) b.push_back(8'h00);
      for (int i = 3; i >= 0; i--) b.push_back(tip[i*8 +: 8]);
      while (b.size() < 68) b.push_back(8'h00);
      c = 32'hFFFF_FFFF;
      for (int i = 8; i < 68; i++) c = crc_upd(c, b[i]);
      c = ~c;
      if (flip) c[5] = ~c[5];
      for (int i = 0; i < 4; i++) b.push_back(c[i*8 +: 8]);
      for (int i = 0; i < b.size(); i++) begin
         @(negedge clk);
         if (i == cut) begin
            early = 1'b1;
            break;
         end
         if (i == rst_at) begin
            early = 1'b1;
            i_gmii_rx_dv = 1'b0;
            i_rst_n = 1'b0;
            @(negedge clk);
            i_rst_n = 1'b1;
            break;
         end
         i_gmii_rx_dv = 1'b1;
         i_gmii_rxd = b[i];
         if (i == 49) tip_cyc = cyc;
      end
      if (!early) @(negedge clk);
      i_gmii_rx_dv = 1'b0;
      i_gmii_rxd = '0;
      fall_cyc = cyc;
      repeat (12) @(negedge clk);
   endtask

   task automatic lookup(input string tag, input logic [31:0] ip,
                         input logic exp_hit, input logic [47:0] exp_mac);
      @(negedge clk);
      i_lookup_req = 1'b1;
      i_lookup_ip = ip;
      @(negedge clk);
      i_lookup_req = 1'b0;
      chk({tag, "_vld"}, 64'(o_lookup_vld), 64'd1);
      chk({tag, "_hit"}, 64'(o_lookup_hit), 64'(exp_hit));
      chk({tag, "_mac"}, 64'(o_lookup_mac), 64'(exp_mac));
   endtask

   task automatic expect_rx(input string tag, input int np, input int ncnt);
      chk({tag, "_pulse"}, 64'(pulses - p0), 64'(np));
      chk({tag, "_cnt"}, 64'(o_cache_cnt), 64'(ncnt));
   endtask

   initial begin
      i_rst_n = 1'b0;
      i_gmii_rx_dv = 1'b0;
      i_gmii_rxd = '0;
      i_lookup_req = 1'b0;
      i_lookup_ip = '0;
      i_cache_clr = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_done", 64'(o_arp_rx_done), 64'd0);
      chk("rst_type", 64'(o_arp_rx_type), 64'd0);
      chk("rst_srcip", 64'(o_arp_srcip_addr), 64'd0);
      chk("rst_srcmac", 64'(o_arp_srcmac_addr), 64'd0);
      chk("rst_lkvld", 64'(o_lookup_vld), 64'd0);
      chk("rst_cnt", 64'(o_cache_cnt), 64'd0);
      i_rst_n = 1'b1;
      @(negedge clk);

      p0 = pulses;
      send_frame(BCAST, 16'h0806, 16'd1, M2, ip_of(2), BIP, -1, -1, 1'b0);
      expect_rx("req", 1, 1);
`ifdef ARP_RX_FCS_CHECK_EN
      chk("req_lat", 64'(pulse_cyc - fall_cyc), 64'd1);
`else
      chk("req_lat", 64'(pulse_cyc - tip_cyc), 64'd1);
`endif
      chk("req_type", 64'(o_arp_rx_type), 64'd0);
      chk("req_srcip", 64'(o_arp_srcip_addr), 64'h0000_0000_C0A8_0102);
      chk("req_srcmac", 64'(o_arp_srcmac_addr), 64'(M2));
      lookup("lk2", ip_of(2), 1'b1, M2);
      lookup("lk99", ip_of(99), 1'b0, '0);
      @(negedge clk);
      chk("lk_idle_vld", 64'(o_lookup_vld), 64'd0);

      p0 = pulses;
      send_frame(BCAST, 16'h0806, 16'd1, mac_of(9), 32'd0, BIP, -1, -1, 1'b0);
      expect_rx("sip0", 1, 1);
      chk("sip0_srcip", 64'(o_arp_srcip_addr), 64'd0);

      p0 = pulses;
      send_frame(BMAC, 16'h0806, 16'd2, mac_of(3), ip_of(3), ip_of(11),
                 -1, -1, 1'b0);
      expect_rx("badtip", 0, 1);
      send_frame(BCAST, 16'h0800, 16'd1, mac_of(3), ip_of(3), BIP,
                 -1, -1, 1'b0);
      expect_rx("ipv4", 0, 1);
      send_frame(BCAST, 16'h0806, 16'd3, mac_of(3), ip_of(3), BIP,
                 -1, -1, 1'b0);
      expect_rx("badop", 0, 1);
      send_frame(48'h02_00_00_00_00_01, 16'h0806, 16'd1, mac_of(3),
                 ip_of(3), BIP, -1, -1, 1'b0);
      expect_rx("baddst", 0, 1);

      p0 = pulses;
      send_frame(BMAC, 16'h0806, 16'd2, mac_of(3), ip_of(3), BIP,
                 -1, -1, 1'b0);
      expect_rx("reply", 1, 2);
      chk("reply_type", 64'(o_arp_rx_type), 64'd1);

      p0 = pulses;
      for (int n = 4; n <= 6; n++)
         send_frame(BCAST, 16'h0806, 16'd1, mac_of(n), ip_of(n), BIP,
                    -1, -1, 1'b0);
      expect_rx("fill", 3, 4);
      lookup("evict2", ip_of(2), 1'b0, '0);
      lookup("hit6", ip_of(6), 1'b1, mac_of(6));

      p0 = pulses;
      send_frame(BCAST, 16'h0806, 16'd1, mac_of(33), ip_of(3), BIP,
                 -1, -1, 1'b0);
      expect_rx("upd3", 1, 4);
      lookup("upd3", ip_of(3), 1'b1, mac_of(33));
      lookup("keep4", ip_of(4), 1'b1, mac_of(4));

      p0 = pulses;
      send_frame(BCAST, 16'h0806, 16'd1, mac_of(7), ip_of(7), BIP,
                 42, -1, 1'b0);
      expect_rx("cut", 0, 4);
      send_frame(BCAST, 16'h0806, 16'd1, mac_of(7), ip_of(7), BIP,
                 -1, -1, 1'b0);
      expect_rx("aftercut", 1, 4);
      lookup("hit7", ip_of(7), 1'b1, mac_of(7));
      lookup("rr3", ip_of(3), 1'b0, '0);

      @(negedge clk);
      i_cache_clr = 1'b1;
      @(negedge clk);
      i_cache_clr = 1'b0;
      chk("clr_cnt", 64'(o_cache_cnt), 64'd0);
      lookup("clr7", ip_of(7), 1'b0, '0);

      p0 = pulses;
      fork
         send_frame(BCAST, 16'h0806, 16'd1, mac_of(8), ip_of(8), BIP,
                    -1, -1, 1'b0);
         begin
            int k;
            k = 0;
            while (!o_arp_rx_done && k < 300) begin
               @(negedge clk);
               k++;
            end
            i_cache_clr = 1'b1;
            @(negedge clk);
            i_cache_clr = 1'b0;
         end
      join
      expect_rx("clrwr", 1, 0);
      lookup("clrwr8", ip_of(8), 1'b0, '0);

      p0 = pulses;
      send_frame(BCAST, 16'h0806, 16'd1, mac_of(9), ip_of(9), BIP,
                 -1, -1, 1'b0);
      expect_rx("pre_rst", 1, 1);
      p0 = pulses;
      send_frame(BCAST, 16'h0806, 16'd1, mac_of(10), ip_of(10), BIP,
                 -1, 30, 1'b0);
      expect_rx("midrst", 0, 0);
      chk("midrst_srcip", 64'(o_arp_srcip_addr), 64'd0);
      p0 = pulses;
      send_frame(BCAST, 16'h0806, 16'd1, mac_of(11), ip_of(11), BIP,
                 -1, -1, 1'b0);
      expect_rx("resync", 1, 1);
      chk("resync_srcip", 64'(o_arp_srcip_addr), 64'(ip_of(11)));

`ifdef ARP_RX_FCS_CHECK_EN
      p0 = pulses;
      send_frame(BCAST, 16'h0806, 16'd1, mac_of(12), ip_of(12), BIP,
                 -1, -1, 1'b0);
      expect_rx("fcs_ok", 1, 2);
      chk("fcs_lat", 64'(pulse_cyc - fall_cyc), 64'd1);
      p0 = pulses;
      send_frame(BCAST, 16'h0806, 16'd1, mac_of(13), ip_of(13), BIP,
                 -1, -1, 1'b1);
      expect_rx("fcs_bad", 0, 2);
      lookup("fcs_bad", ip_of(13), 1'b0, '0);
`endif

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
